// File: rtl/multicore_pkg.sv
// Shared types and encodings for the multicore pipeline.
// Holds branch function codes and the BHT counter type.
package multicore_pkg;

    localparam int DATA_SIZE = 32;

    typedef logic [2:0] t_brop;

    localparam t_brop BR_BEQ  = 3'b000;
    localparam t_brop BR_BNE  = 3'b001;
    localparam t_brop BR_BLT  = 3'b100;
    localparam t_brop BR_BGE  = 3'b101;
    localparam t_brop BR_BLTU = 3'b110;
    localparam t_brop BR_BGEU = 3'b111;

    typedef logic [1:0] t_bht_ctr;

    localparam t_bht_ctr BHT_WNT = 2'b01;

    // Saturating 2-bit counter step toward the resolved direction.
    function automatic t_bht_ctr bht_next(t_bht_ctr c, logic taken);
        if (taken) begin
            return (c == 2'b11) ? c : c + 2'b01;
        end
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

endpackage

// File: rtl/bht_table.sv
// Table of 2-bit saturating direction counters.
// After reset it sweeps every entry to weakly not-taken while busy.
module bht_table
    import multicore_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int IW      = $clog2(ENTRIES)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [IW-1:0]  i_rd_idx,
    output t_bht_ctr       o_rd_ctr,
    input  logic           i_upd_en,
    input  logic [IW-1:0]  i_upd_idx,
    input  logic           i_upd_taken,
    output logic           o_busy
);

    t_bht_ctr      mem_q [ENTRIES];
    logic          busy_q, busy_d;
    logic [IW-1:0] sweep_q, sweep_d;
    logic          we;
    logic [IW-1:0] widx;
    t_bht_ctr      wdata;

    always_comb begin
        busy_d  = busy_q;
        sweep_d = sweep_q;
        we      = 1'b0;
        widx    = i_upd_idx;
        wdata   = bht_next(mem_q[i_upd_idx], i_upd_taken);
        if (busy_q) begin
            we      = 1'b1;
            widx    = sweep_q;
            wdata   = BHT_WNT;
            sweep_d = sweep_q + IW'(1);
            busy_d  = (sweep_q != IW'(ENTRIES - 1));
        end else if (i_upd_en) begin
            we = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            busy_q  <= 1'b1;
            sweep_q <= '0;
        end else begin
            busy_q  <= busy_d;
            sweep_q <= sweep_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (we) begin
            mem_q[widx] <= wdata;
        end
    end

    assign o_rd_ctr = mem_q[i_rd_idx];
    assign o_busy   = busy_q;

endmodule

// File: rtl/branch_resolve.sv
// Resolves conditional branches one cycle after acceptance and
// trains the direction predictor and statistics counters.
module branch_resolve
    import multicore_pkg::*;
#(
    parameter int DATA_SIZE   = multicore_pkg::DATA_SIZE,
    parameter int BHT_ENTRIES = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_flush,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  t_brop                i_funct,
    input  logic [DATA_SIZE-1:0] i_r1,
    input  logic [DATA_SIZE-1:0] i_r2,
    input  logic [DATA_SIZE-1:0] i_pc,
    input  logic [DATA_SIZE-1:0] i_imm,
    input  logic                 i_pred_taken,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_taken,
    output logic                 o_mispredict,
    output logic                 o_illegal,
    output logic [DATA_SIZE-1:0] o_redirect_pc,
    input  logic [DATA_SIZE-1:0] i_lookup_pc,
    output logic                 o_lookup_taken,
    output logic [31:0]          o_branch_cnt,
    output logic [31:0]          o_mispredict_cnt
);

    localparam int IW = $clog2(BHT_ENTRIES);

    logic                 valid_q, valid_d;
    logic                 taken_q, taken_d;
    logic                 mis_q, mis_d;
    logic                 ill_q, ill_d;
    logic [DATA_SIZE-1:0] redir_q, redir_d;
    logic [31:0]          bcnt_q, bcnt_d;
    logic [31:0]          mcnt_q, mcnt_d;

    logic                 bht_busy;
    t_bht_ctr             lookup_ctr;
    logic                 accept;
    logic                 legal;
    logic                 taken_c;
    logic [DATA_SIZE-1:0] target;
    logic [DATA_SIZE-1:0] fall;
    logic                 unused_addr_bits;

    assign o_ready = !bht_busy && (!valid_q || i_ready);
    assign accept  = i_valid && o_ready && !i_flush && !i_rst;
    assign target  = i_pc + i_imm;
    assign fall    = i_pc + DATA_SIZE'(4);

    always_comb begin
        legal   = 1'b1;
        taken_c = 1'b0;
        unique case (i_funct)
            BR_BEQ:  taken_c = (i_r1 == i_r2);
            BR_BNE:  taken_c = (i_r1 != i_r2);
            BR_BLT:  taken_c = ($signed(i_r1) < $signed(i_r2));
            BR_BGE:  taken_c = ($signed(i_r1) >= $signed(i_r2));
            BR_BLTU: taken_c = (i_r1 < i_r2);
            BR_BGEU: taken_c = (i_r1 >= i_r2);
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        taken_d = taken_q;
        mis_d   = mis_q;
        ill_d   = ill_q;
        redir_d = redir_q;
        bcnt_d  = bcnt_q;
        mcnt_d  = mcnt_q;
        if (accept) begin
            valid_d = 1'b1;
            taken_d = taken_c;
            ill_d   = !legal;
            mis_d   = legal && (taken_c ^ i_pred_taken);
            redir_d = taken_c ? target : fall;
            if (legal) begin
                bcnt_d = bcnt_q + 32'd1;
            end
            if (legal && (taken_c ^ i_pred_taken)) begin
                mcnt_d = mcnt_q + 32'd1;
            end
        end else if (i_flush || i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            taken_q <= 1'b0;
            mis_q   <= 1'b0;
            ill_q   <= 1'b0;
            redir_q <= '0;
            bcnt_q  <= '0;
            mcnt_q  <= '0;
        end else begin
            valid_q <= valid_d;
            taken_q <= taken_d;
            mis_q   <= mis_d;
            ill_q   <= ill_d;
            redir_q <= redir_d;
            bcnt_q  <= bcnt_d;
            mcnt_q  <= mcnt_d;
        end
    end

    bht_table #(
        .ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_rd_idx    (i_lookup_pc[IW+1:2]),
        .o_rd_ctr    (lookup_ctr),
        .i_upd_en    (accept && legal),
        .i_upd_idx   (i_pc[IW+1:2]),
        .i_upd_taken (taken_c),
        .o_busy      (bht_busy)
    );

    // Only the index field of each PC addresses the table.
    assign unused_addr_bits = ^{i_lookup_pc, i_pc, lookup_ctr[0]};

    assign o_lookup_taken   = lookup_ctr[1];
    assign o_valid          = valid_q;
    assign o_taken          = taken_q;
    assign o_mispredict     = mis_q;
    assign o_illegal        = ill_q;
    assign o_redirect_pc    = redir_q;
    assign o_branch_cnt     = bcnt_q;
    assign o_mispredict_cnt = mcnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: directed table, corner sequences,
// and randomized requests against a behavioural model.
module tb_branch_resolve;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        valid_in;
    logic        ready_out;
    logic [2:0]  funct;
    logic [31:0] r1, r2, pc, imm;
    logic        pred;
    logic        valid_out;
    logic        ready_in;
    logic        taken;
    logic        mis;
    logic        ill;
    logic [31:0] redir;
    logic [31:0] lk_pc;
    logic        lk_taken;
    logic [31:0] bcnt;
    logic [31:0] mcnt;

    branch_resolve dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_flush          (flush),
        .i_valid          (valid_in),
        .o_ready          (ready_out),
        .i_funct          (funct),
        .i_r1             (r1),
        .i_r2             (r2),
        .i_pc             (pc),
        .i_imm            (imm),
        .i_pred_taken     (pred),
        .o_valid          (valid_out),
        .i_ready          (ready_in),
        .o_taken          (taken),
        .o_mispredict     (mis),
        .o_illegal        (ill),
        .o_redirect_pc    (redir),
        .i_lookup_pc      (lk_pc),
        .o_lookup_taken   (lk_taken),
        .o_branch_cnt     (bcnt),
        .o_mispredict_cnt (mcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        pred;
    } req_t;

    typedef struct {
        logic        taken;
        logic        illegal;
        logic        mis;
        logic [31:0] redir;
    } res_t;

    typedef struct {
        req_t        rq;
        res_t        ex;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    int          m_bht [64];
    int unsigned m_bcnt;
    int unsigned m_mcnt;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic int idx_of(logic [31:0] a);
        return int'((a >> 2) % 64);
    endfunction

    function automatic int m_lookup(logic [31:0] a);
        return (m_bht[idx_of(a)] >= 2) ? 1 : 0;
    endfunction

    function automatic res_t model_eval(req_t q);
        res_t r;
        int   sa, sb;
        sa = q.a;
        sb = q.b;
        r.illegal = 1'b0;
        case (q.f)
            3'd0: r.taken = (q.a == q.b);
            3'd1: r.taken = (q.a != q.b);
            3'd4: r.taken = (sa < sb);
            3'd5: r.taken = (sa >= sb);
            3'd6: r.taken = (q.a < q.b);
            3'd7: r.taken = (q.a >= q.b);
            default: begin
                r.taken   = 1'b0;
                r.illegal = 1'b1;
            end
        endcase
        r.mis   = !r.illegal && (r.taken != q.pred);
        r.redir = r.taken ? q.pc + q.imm : q.pc + 32'd4;
        return r;
    endfunction

    task automatic model_commit(input req_t q);
        res_t r;
        int   i;
        r = model_eval(q);
        if (!r.illegal) begin
            i = idx_of(q.pc);
            if (r.taken) m_bht[i] = (m_bht[i] == 3) ? 3 : m_bht[i] + 1;
            else         m_bht[i] = (m_bht[i] == 0) ? 0 : m_bht[i] - 1;
            m_bcnt++;
            if (r.mis) m_mcnt++;
        end
    endtask

    task automatic drive(input req_t q);
        funct    = q.f;
        r1       = q.a;
        r2       = q.b;
        pc       = q.pc;
        imm      = q.imm;
        pred     = q.pred;
        valid_in = 1'b1;
    endtask

    task automatic check_out(input string tag, input res_t e);
        check({tag, ".valid"}, 64'(valid_out), 64'd1);
        check({tag, ".taken"}, 64'(taken), 64'(e.taken));
        check({tag, ".illegal"}, 64'(ill), 64'(e.illegal));
        check({tag, ".mis"}, 64'(mis), 64'(e.mis));
        check({tag, ".redir"}, 64'(redir), 64'(e.redir));
        check({tag, ".bcnt"}, 64'(bcnt), 64'(m_bcnt));
        check({tag, ".mcnt"}, 64'(mcnt), 64'(m_mcnt));
    endtask

    // One request with the consumer always ready; checks old/new BHT view.
    task automatic send(input string tag, input req_t q);
        res_t e;
        e        = model_eval(q);
        drive(q);
        ready_in = 1'b1;
        flush    = 1'b0;
        lk_pc    = q.pc;
        #1;
        check({tag, ".ready"}, 64'(ready_out), 64'd1);
        check({tag, ".lk_old"}, 64'(lk_taken), 64'(m_lookup(q.pc)));
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        model_commit(q);
        check_out(tag, e);
        check({tag, ".lk_new"}, 64'(lk_taken), 64'(m_lookup(q.pc)));
    endtask

    function automatic req_t mk(logic [2:0] f, logic [31:0] a, logic [31:0] b,
                                logic [31:0] p, logic [31:0] i, logic pr);
        req_t q;
        q.f = f; q.a = a; q.b = b; q.pc = p; q.imm = i; q.pred = pr;
        return q;
    endfunction

    function automatic res_t mr(logic t, logic il, logic m, logic [31:0] rd);
        res_t r;
        r.taken = t; r.illegal = il; r.mis = m; r.redir = rd;
        return r;
    endfunction

    vec_t vecs [9];

    initial begin
        req_t qa, qb;
        res_t ea, eb;
        int   waited;

        rst = 1'b1; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
        funct = '0; r1 = '0; r2 = '0; pc = '0; imm = '0; pred = 1'b0;
        lk_pc = 32'h40;
        for (int i = 0; i < 64; i++) m_bht[i] = 1;
        m_bcnt = 0;
        m_mcnt = 0;

        repeat (2) @(posedge clk);
        #1;
        check("rst.valid", 64'(valid_out), 64'd0);
        check("rst.taken", 64'(taken), 64'd0);
        check("rst.mis", 64'(mis), 64'd0);
        check("rst.illegal", 64'(ill), 64'd0);
        check("rst.redir", 64'(redir), 64'd0);
        check("rst.bcnt", 64'(bcnt), 64'd0);
        check("rst.mcnt", 64'(mcnt), 64'd0);
        rst = 1'b0;

        waited = 0;
        while (!ready_out && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("bht_sweep_done", 64'(ready_out), 64'd1);
        if (!ready_out) begin
            $display("FAIL bht_sweep: never ready");
            $fatal(1, "sweep timeout");
        end

        // Signed less-than, mispredicted as not-taken.
        send("blt", mk(3'd4, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1'b0));
        check("blt.taken_k", 64'(taken), 64'd1);
        check("blt.redir_k", 64'(redir), 64'h120);
        check("blt.mis_k", 64'(mis), 64'd1);
        check("blt.mcnt_k", 64'(mcnt), 64'd1);

        // Counter training at one PC, saturation, then decay.
        lk_pc = 32'h40;
        #1;
        check("sat.lk0", 64'(lk_taken), 64'd0);
        for (int k = 0; k < 4; k++) begin
            send("sat.t", mk(3'd0, 32'd9, 32'd9, 32'h40, 32'h8, 1'b1));
            check("sat.lk1", 64'(lk_taken), 64'd1);
        end
        send("sat.n1", mk(3'd1, 32'd9, 32'd9, 32'h40, 32'h8, 1'b1));
        check("sat.lk_after_one_nt", 64'(lk_taken), 64'd1);
        send("sat.n2", mk(3'd1, 32'd9, 32'd9, 32'h40, 32'h8, 1'b1));
        check("sat.lk_after_two_nt", 64'(lk_taken), 64'd0);

        vecs[0] = '{mk(3'd6, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 1'b0),
                    mr(1'b0, 1'b0, 1'b0, 32'h204)};
        vecs[1] = '{mk(3'd0, 32'd5, 32'd5, 32'h300, 32'hFFFF_FFF0, 1'b1),
                    mr(1'b1, 1'b0, 1'b0, 32'h2F0)};
        vecs[2] = '{mk(3'd1, 32'd5, 32'd5, 32'h304, 32'h8, 1'b1),
                    mr(1'b0, 1'b0, 1'b1, 32'h308)};
        vecs[3] = '{mk(3'd5, 32'hFFFF_FFFF, 32'd1, 32'h400, 32'h40, 1'b0),
                    mr(1'b0, 1'b0, 1'b0, 32'h404)};
        vecs[4] = '{mk(3'd7, 32'hFFFF_FFFF, 32'd1, 32'h500, 32'h100, 1'b0),
                    mr(1'b1, 1'b0, 1'b1, 32'h600)};
        vecs[5] = '{mk(3'd4, 32'd1, 32'd2, 32'hFFFF_FFF0, 32'h20, 1'b1),
                    mr(1'b1, 1'b0, 1'b0, 32'h10)};
        vecs[6] = '{mk(3'd1, 32'd3, 32'd3, 32'hFFFF_FFFC, 32'h8, 1'b0),
                    mr(1'b0, 1'b0, 1'b0, 32'h0)};
        vecs[7] = '{mk(3'd2, 32'd1, 32'd2, 32'h600, 32'h40, 1'b1),
                    mr(1'b0, 1'b1, 1'b0, 32'h604)};
        vecs[8] = '{mk(3'd3, 32'd7, 32'd7, 32'h700, 32'h40, 1'b0),
                    mr(1'b0, 1'b1, 1'b0, 32'h704)};

        for (int v = 0; v < 9; v++) begin
            int unsigned b0;
            b0 = m_bcnt;
            send($sformatf("vec%0d", v), vecs[v].rq);
            check($sformatf("vec%0d.taken_k", v), 64'(taken),
                  64'(vecs[v].ex.taken));
            check($sformatf("vec%0d.ill_k", v), 64'(ill),
                  64'(vecs[v].ex.illegal));
            check($sformatf("vec%0d.mis_k", v), 64'(mis),
                  64'(vecs[v].ex.mis));
            check($sformatf("vec%0d.redir_k", v), 64'(redir),
                  64'(vecs[v].ex.redir));
            check($sformatf("vec%0d.bcnt_k", v), 64'(bcnt),
                  64'(b0 + (vecs[v].ex.illegal ? 0 : 1)));
        end

        // Back-pressure: result A held while B waits.
        valid_in = 1'b0;
        ready_in = 1'b1;
        @(posedge clk);
        #1;
        qa = mk(3'd5, 32'd10, 32'd3, 32'h800, 32'h30, 1'b0);
        qb = mk(3'd6, 32'd2, 32'd3, 32'h900, 32'h44, 1'b0);
        ea = model_eval(qa);
        eb = model_eval(qb);
        drive(qa);
        ready_in = 1'b0;
        #1;
        check("stall.ready_a", 64'(ready_out), 64'd1);
        @(posedge clk);
        #1;
        model_commit(qa);
        check_out("stall.a", ea);
        drive(qb);
        for (int c = 0; c < 3; c++) begin
            check("stall.ready_b", 64'(ready_out), 64'd0);
            check_out("stall.hold", ea);
            @(posedge clk);
            #1;
        end
        ready_in = 1'b1;
        #1;
        check("stall.ready_rel", 64'(ready_out), 64'd1);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        model_commit(qb);
        check_out("stall.b", eb);

        // Flush beats a same-cycle request; nothing trains or counts.
        send("pre_flush", mk(3'd0, 32'd1, 32'd1, 32'h80, 32'h4, 1'b1));
        drive(mk(3'd0, 32'd4, 32'd4, 32'h40, 32'h10, 1'b0));
        flush = 1'b1;
        lk_pc = 32'h40;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        valid_in = 1'b0;
        check("flush.valid", 64'(valid_out), 64'd0);
        check("flush.bcnt", 64'(bcnt), 64'(m_bcnt));
        check("flush.mcnt", 64'(mcnt), 64'(m_mcnt));
        check("flush.lk", 64'(lk_taken), 64'(m_lookup(32'h40)));

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            req_t q;
            q.f    = 3'($urandom_range(0, 7));
            q.a    = $urandom();
            q.b    = ($urandom_range(0, 3) == 0) ? q.a : $urandom();
            if ($urandom_range(0, 1) == 1)
                q.pc = 32'h1000 + (32'($urandom_range(0, 7)) << 2);
            else
                q.pc = $urandom() & 32'hFFFF_FFFC;
            q.imm  = $urandom();
            q.pred = 1'($urandom_range(0, 1));
            send("rand", q);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
                check("rand.idle_valid", 64'(valid_out), 64'd0);
            end
        end

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst2.valid", 64'(valid_out), 64'd0);
        check("rst2.bcnt", 64'(bcnt), 64'd0);
        check("rst2.mcnt", 64'(mcnt), 64'd0);
        check("rst2.ready", 64'(ready_out), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 The module SHALL have parameter DATA_SIZE, default DATA_SIZE from multicore_pkg, giving the operand/PC width in bits.
REQ-002 The module SHALL have parameter BHT_ENTRIES, default 64, giving the branch history table depth (power of two, 4..1024).
REQ-003 The module SHALL have port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port i_rst, input, 1, a synchronous active-high reset.
REQ-005 The module SHALL have port i_flush, input, 1, which discards in-flight work.
REQ-006 The module SHALL have request port i_valid, input, 1, and o_ready, output, 1.
REQ-007 The module SHALL have port i_funct, input, t_brop, the branch function.
REQ-008 The module SHALL have ports i_r1 and i_r2, input, DATA_SIZE, the operands.
REQ-009 The module SHALL have ports i_pc and i_imm, input, DATA_SIZE, the branch PC and the sign-extended offset.
REQ-010 The module SHALL have port i_pred_taken, input, 1, the direction fetch predicted.
REQ-011 The module SHALL have result port o_valid, output, 1, and i_ready, input, 1.
REQ-012 The module SHALL have result ports o_taken 1, o_mispredict 1, o_illegal 1 and o_redirect_pc DATA_SIZE, all outputs.
REQ-013 The module SHALL have lookup ports i_lookup_pc, input, DATA_SIZE, and o_lookup_taken, output, 1.
REQ-014 The module SHALL have counter ports o_branch_cnt and o_mispredict_cnt, outputs, 32.

Function
REQ-015 A request SHALL be accepted when i_valid && o_ready && !i_flush; o_ready = !o_valid || i_ready.
REQ-016 Latency SHALL be 1 cycle: an accepted request appears registered on the outputs with o_valid=1 in the next cycle.
REQ-017 Results SHALL hold stable while o_valid && !i_ready; a result SHALL retire on o_valid && i_ready.
REQ-018 Taken decode SHALL be: 000 BEQ r1==r2; 001 BNE r1!=r2; 100 BLT signed <; 101 BGE signed >=; 110 BLTU unsigned <; 111 BGEU unsigned >=.
REQ-019 Funct 010 or 011 SHALL give o_taken=0, o_illegal=1, o_mispredict=0, with no BHT or counter update.
REQ-020 The target SHALL be i_pc+i_imm modulo 2^DATA_SIZE; the fall-through SHALL be i_pc+4 modulo 2^DATA_SIZE.
REQ-021 o_redirect_pc SHALL equal the target when taken, otherwise the fall-through.
REQ-022 o_mispredict SHALL equal o_taken XOR i_pred_taken as captured at acceptance.
REQ-023 The BHT SHALL hold BHT_ENTRIES 2-bit saturating counters, indexed by pc[$clog2(BHT_ENTRIES)+1:2].
REQ-024 o_lookup_taken SHALL be combinational and equal bit 1 of the entry indexed by i_lookup_pc.
REQ-025 At acceptance of a legal request, the indexed BHT entry SHALL increment if taken (saturating at 11) or decrement if not taken (saturating at 00).
REQ-026 The BHT write SHALL be visible to lookups from the following cycle; a same-cycle lookup SHALL return the old value.
REQ-027 o_branch_cnt SHALL increment on each legal acceptance; o_mispredict_cnt SHALL increment on each accepted mispredict; both SHALL wrap at 2^32.
REQ-028 i_flush SHALL clear o_valid next cycle and block acceptance that cycle (flush wins over i_valid); BHT and counters SHALL be unchanged by a flush.

Reset
REQ-029 On i_rst: o_valid=0, o_taken=0, o_mispredict=0, o_illegal=0, o_redirect_pc=0, both counters=0, all BHT entries=01 (weakly not-taken).
REQ-030 i_rst SHALL take priority over i_flush and i_valid; BHT reset MAY take BHT_ENTRIES cycles with o_ready=0 throughout, but SHALL complete before the first acceptance.

Structure
REQ-031 t_brop, the funct encodings, DATA_SIZE and a t_bht_ctr 2-bit type SHALL live in multicore_pkg.
REQ-032 The 2-bit counter table SHALL be a sub-module bht_table (read port, write port, reset sweep); the compare logic stays inline.

Verification
REQ-033 Reset, then BLT r1=-1, r2=1, pc=0x100, imm=0x20, pred=0 -> next cycle o_valid=1, taken=1, redirect=0x120, mispredict=1, mispredict_cnt=1.
REQ-034 BLTU r1=0xFFFFFFFF, r2=1, pc=0x200, pred=0 -> taken=0, redirect=0x204, mispredict=0.
REQ-035 Three taken branches at pc=0x40 -> lookup(0x40) reads 0 after reset, 1 after the first update; the entry saturates at 11, and a fourth taken branch leaves it at 11.
REQ-036 Hold i_ready=0 with o_valid=1 and a new i_valid -> o_ready=0, outputs stable, branch_cnt unchanged until i_ready=1.
REQ-037 i_flush with i_valid in the same cycle -> no acceptance, o_valid=0 next cycle, counters and BHT unchanged; funct 010 -> o_illegal=1, branch_cnt unchanged.
